// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings for the slave memory: burst types, response codes and
// the state encodings of the independent write and read FSMs.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; every beat is a
// full data-bus-width beat, so the step is always BYTES.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    incr_addr = addr + ADDR_WIDTH'(BYTES);
    wrap_mask = '0;
    case (len)
      8'd1:    wrap_mask = ADDR_WIDTH'(2 * BYTES - 1);
      8'd3:    wrap_mask = ADDR_WIDTH'(4 * BYTES - 1);
      8'd7:    wrap_mask = ADDR_WIDTH'(8 * BYTES - 1);
      8'd15:   wrap_mask = ADDR_WIDTH'(16 * BYTES - 1);
      default: wrap_mask = '0;
    endcase

    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      // An illegal WRAP length leaves the mask at zero and degrades to INCR.
      BURST_WRAP:  next_addr = (wrap_mask == '0) ? incr_addr
                             : ((addr & ~wrap_mask) | (incr_addr & wrap_mask));
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed register array. One outstanding write
// and one outstanding read, each handled by its own FSM.
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ID_WIDTH-1:0]     S_AXI_awid,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [7:0]              S_AXI_awlen,
  input  logic [2:0]              S_AXI_awsize,
  input  logic [1:0]              S_AXI_awburst,
  input  logic [1:0]              S_AXI_awlock,
  input  logic [3:0]              S_AXI_awcache,
  input  logic [2:0]              S_AXI_awprot,
  input  logic [3:0]              S_AXI_awregion,
  input  logic [3:0]              S_AXI_awqos,
  input  logic                    S_AXI_awvalid,
  output logic                    S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                    S_AXI_wlast,
  input  logic                    S_AXI_wvalid,
  output logic                    S_AXI_wready,
  output logic [ID_WIDTH-1:0]     S_AXI_bid,
  output logic [1:0]              S_AXI_bresp,
  output logic                    S_AXI_bvalid,
  input  logic                    S_AXI_bready,
  input  logic [ID_WIDTH-1:0]     S_AXI_arid,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [7:0]              S_AXI_arlen,
  input  logic [2:0]              S_AXI_arsize,
  input  logic [1:0]              S_AXI_arburst,
  input  logic [1:0]              S_AXI_arlock,
  input  logic [3:0]              S_AXI_arcache,
  input  logic [2:0]              S_AXI_arprot,
  input  logic [3:0]              S_AXI_arregion,
  input  logic [3:0]              S_AXI_arqos,
  input  logic                    S_AXI_arvalid,
  output logic                    S_AXI_arready,
  output logic [ID_WIDTH-1:0]     S_AXI_rid,
  output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]              S_AXI_rresp,
  output logic                    S_AXI_rlast,
  output logic                    S_AXI_rvalid,
  input  logic                    S_AXI_rready
);

  localparam int                  BYTES      = DATA_WIDTH / 8;
  localparam int                  LOG2_BYTES = $clog2(BYTES);
  localparam int                  IDX_WIDTH  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES  = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a - BASE_ADDR};
    return (a >= BASE_ADDR) && (off < MEM_BYTES);
  endfunction

  function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_WIDTH'((a - BASE_ADDR) >> LOG2_BYTES);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  rst_done;

  logic [1:0]            w_state;
  logic [ADDR_WIDTH-1:0] w_addr, w_next_addr;
  logic [7:0]            w_len;
  logic [1:0]            w_burst;
  logic [8:0]            w_cnt;
  logic                  w_err;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_next_addr, rd_addr;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst, rd_burst;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_awsize, S_AXI_awlock, S_AXI_awcache, S_AXI_awprot,
                       S_AXI_awregion, S_AXI_awqos, S_AXI_arsize, S_AXI_arlock,
                       S_AXI_arcache, S_AXI_arprot, S_AXI_arregion, S_AXI_arqos};

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_w_addr_gen (
    .addr(w_addr), .len(w_len), .burst(w_burst), .next_addr(w_next_addr)
  );
  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_r_addr_gen (
    .addr(r_addr), .len(r_len), .burst(r_burst), .next_addr(r_next_addr)
  );

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of block ordering.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  assign S_AXI_awready = rst_done && (w_state == W_IDLE);
  assign S_AXI_wready  = (w_state == W_DATA);
  assign S_AXI_arready = rst_done && (r_state == R_IDLE);

  logic w_fire, w_in_burst, w_addr_ok, w_we, w_beat_err;
  assign w_fire     = S_AXI_wvalid && S_AXI_wready;
  assign w_in_burst = (w_cnt <= {1'b0, w_len});
  assign w_addr_ok  = in_range(w_addr) && (w_burst != BURST_RSVD);
  assign w_we       = w_fire && w_in_burst && w_addr_ok;
  // wlast must coincide with beat awlen; beats past the burst only drop.
  assign w_beat_err = (w_in_burst && !w_addr_ok) || (S_AXI_wlast != (w_cnt == {1'b0, w_len}));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state      <= W_IDLE;
      w_addr       <= '0;
      w_len        <= '0;
      w_burst      <= BURST_FIXED;
      w_cnt        <= '0;
      w_err        <= 1'b0;
      S_AXI_bvalid <= 1'b0;
      S_AXI_bresp  <= RESP_OKAY;
      S_AXI_bid    <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (S_AXI_awvalid && S_AXI_awready) begin
          w_addr    <= S_AXI_awaddr;
          w_len     <= S_AXI_awlen;
          w_burst   <= S_AXI_awburst;
          w_cnt     <= '0;
          w_err     <= (S_AXI_awburst == BURST_RSVD);
          S_AXI_bid <= S_AXI_awid;
          w_state   <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          w_addr <= w_next_addr;
          w_err  <= w_err | w_beat_err;
          if (w_in_burst) w_cnt <= w_cnt + 9'd1;
          if (S_AXI_wlast) begin
            S_AXI_bvalid <= 1'b1;
            S_AXI_bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            w_state      <= W_RESP;
          end
        end
        W_RESP: if (S_AXI_bready) begin
          S_AXI_bvalid <= 1'b0;
          w_state      <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; its contents survive ARESETN by design.
  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (S_AXI_wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
      end
    end
  end

  // Read port address: the AR address for beat 0, the generated address after.
  logic rd_err;
  assign rd_addr  = (r_state == R_IDLE) ? S_AXI_araddr  : r_next_addr;
  assign rd_burst = (r_state == R_IDLE) ? S_AXI_arburst : r_burst;
  assign rd_err   = !in_range(rd_addr) || (rd_burst == BURST_RSVD);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= R_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_burst      <= BURST_FIXED;
      r_cnt        <= '0;
      S_AXI_rvalid <= 1'b0;
      S_AXI_rid    <= '0;
      S_AXI_rdata  <= '0;
      S_AXI_rresp  <= RESP_OKAY;
      S_AXI_rlast  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (S_AXI_arvalid && S_AXI_arready) begin
          r_addr       <= S_AXI_araddr;
          r_len        <= S_AXI_arlen;
          r_burst      <= S_AXI_arburst;
          r_cnt        <= '0;
          S_AXI_rvalid <= 1'b1;
          S_AXI_rid    <= S_AXI_arid;
          S_AXI_rdata  <= rd_err ? '0 : mem[word_idx(rd_addr)];
          S_AXI_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
          S_AXI_rlast  <= (S_AXI_arlen == 8'd0);
          r_state      <= R_DATA;
        end
        R_DATA: if (S_AXI_rvalid && S_AXI_rready) begin
          if (S_AXI_rlast) begin
            S_AXI_rvalid <= 1'b0;
            S_AXI_rlast  <= 1'b0;
            r_state      <= R_IDLE;
          end else begin
            r_addr      <= r_next_addr;
            r_cnt       <= r_cnt + 8'd1;
            S_AXI_rdata <= rd_err ? '0 : mem[word_idx(rd_addr)];
            S_AXI_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            S_AXI_rlast <= (r_cnt + 8'd1 == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
